fft_seq_ctrl: RTL

Frame sequencer for the 4-point FFT datapath. It accepts sample-load strobes from io_ctrl and steers them into memory_ctrl slots in strict order. It waits a fixed FFT pipeline latency, raises a one-cycle snapshot strobe, then steps the readout index on output strobes. It replaces the ad-hoc processing/done/output_counter logic in the top level and adds ordering checks, an explicit state encoding and a defined abort path.

---
 rtl/fft_seq_ctrl.sv | 88 ++++++++
 1 files changed

// File: rtl/fft_seq_ctrl.sv
// fft_seq_ctrl: ordered sample loading, fixed-latency FFT wait, snapshot strobe and result readout sequencing
module fft_seq_ctrl #(
  parameter int N_SAMPLES   = 4,
  parameter int IDX_W       = 2,
  parameter int FFT_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 load_pulse,
  input  logic [IDX_W-1:0]     load_addr,
  input  logic                 output_pulse,
  output logic                 wr_en,
  output logic [N_SAMPLES-1:0] wr_sel,
  output logic                 snap_en,
  output logic                 busy,
  output logic                 done,
  output logic [IDX_W-1:0]     rd_idx,
  output logic                 rd_oe,
  output logic [1:0]           state,
  output logic                 err_seq
);
  localparam int LAT_W = $clog2(FFT_LATENCY + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_SAMPLES - 1);
  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, READOUT} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] exp_q, exp_d, rd_q, rd_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic snap_q, snap_d, err_q, err_d, busy_q, done_q, oe_q, acc;
  always_comb begin
    acc     = ena & load_pulse & (load_addr == exp_q) & (state_q != COMPUTE);
    state_d = state_q;
    exp_d   = exp_q;
    rd_d    = rd_q;
    lat_d   = lat_q;
    snap_d  = snap_q;
    err_d   = err_q | (ena & load_pulse & ~acc);
    if (ena) begin
      // registered strobe lands in the cycle where lat_q has reached zero
      snap_d = (state_q == COMPUTE) && (lat_q == LAT_W'(1));
      if (acc) begin
        state_d = (load_addr == LAST) ? COMPUTE : LOAD;
        exp_d   = exp_q + IDX_W'(1);
        lat_d   = LAT_W'(FFT_LATENCY);
        rd_d    = '0;
      end else if (state_q == COMPUTE) begin
        lat_d   = (lat_q != '0) ? lat_q - LAT_W'(1) : lat_q;
        state_d = (lat_q == '0) ? READOUT : COMPUTE;
        rd_d    = '0;
      end else if (state_q == READOUT && output_pulse) begin
        rd_d    = rd_q + IDX_W'(1);
        state_d = (rd_q == LAST) ? IDLE : READOUT;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      exp_q   <= '0;
      rd_q    <= '0;
      lat_q   <= '0;
      snap_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      rd_q    <= rd_d;
      lat_q   <= lat_d;
      snap_q  <= snap_d;
      err_q   <= err_d;
      busy_q  <= state_d == COMPUTE;
      done_q  <= state_d == READOUT;
      oe_q    <= state_d == READOUT;
    end
  end
  assign wr_en   = acc;
  assign wr_sel  = acc ? N_SAMPLES'(1) << load_addr : '0;
  assign snap_en = snap_q & ena;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_oe   = oe_q;
  assign rd_idx  = rd_q;
  assign state   = state_q;
  assign err_seq = err_q;
endmodule
